// File: rtl/ifm_pkg.sv
// Shared constants and index helpers for the multi-lane IFM shift-window buffer.
package ifm_pkg;

  localparam int DATA_W_DEF = 8;

  // Fill counter must be able to represent DEPTH itself, hence DEPTH+1 codes.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

  function automatic int tap_lsb(input int lane, input int tap, input int depth, input int data_w);
    return (lane * depth + tap) * data_w;
  endfunction

endpackage

// File: rtl/ifm_win_buf_if.sv
// Control/data bundle between the PE controller and the IFM window buffer.
// The pad input exists only when IFM_WIN_PAD_EN is defined.
interface ifm_win_buf_if
  import ifm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int LANES  = 1
) ();

  localparam int FILL_W = fill_w(DEPTH);

  logic                          stall;
  logic                          ifm_read;
  logic                          flush;
  logic [LANES*DATA_W-1:0]       ifm_input;
`ifdef IFM_WIN_PAD_EN
  logic                          pad;
`endif
  logic [LANES*DEPTH*DATA_W-1:0] ifm_win;
  logic                          win_valid;
  logic [FILL_W-1:0]             fill_cnt;

  modport master (
    output stall, ifm_read, flush, ifm_input,
`ifdef IFM_WIN_PAD_EN
    output pad,
`endif
    input  ifm_win, win_valid, fill_cnt
  );

  modport slave (
    input  stall, ifm_read, flush, ifm_input,
`ifdef IFM_WIN_PAD_EN
    input  pad,
`endif
    output ifm_win, win_valid, fill_cnt
  );

endinterface

// File: rtl/ifm_lane_shift.sv
// DEPTH-tap shift register for one lane; tap 0 is the newest sample.
// Clear has priority over enable.
module ifm_lane_shift #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DATA_W-1:0]       din_i,
  output logic [DEPTH*DATA_W-1:0] taps_o
);

  logic [DEPTH-1:0][DATA_W-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clr_i) begin
      taps_d = '0;
    end else if (en_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        taps_d[k] = taps_q[k-1];
      end
      taps_d[0] = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/ifm_win_buf.sv
// Multi-lane IFM shift-window buffer with fill tracking, strided window-valid and flush.
// Optional macro IFM_WIN_PAD_EN adds a pad input that shifts in zeros on all lanes.
module ifm_win_buf
  import ifm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int LANES  = 1,
  parameter int STRIDE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ifm_win_buf_if.slave bus
);

  localparam int FW  = fill_w(DEPTH);
  localparam int SCW = cnt_w(STRIDE);
  localparam logic [FW-1:0]  FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0]  FILL_LAST = FW'(DEPTH - 1);
  localparam logic [SCW-1:0] SC_LAST   = SCW'(STRIDE - 1);

  logic           shift;
  logic [FW-1:0]  fill_q, fill_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           valid_q, valid_d;

  // Flush and stall both suppress the shift; flush additionally clears everything.
  assign shift = bus.ifm_read & ~bus.stall & ~bus.flush;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_W-1:0]       din;
    logic [DEPTH*DATA_W-1:0] taps;

`ifdef IFM_WIN_PAD_EN
    assign din = bus.pad ? '0 : bus.ifm_input[lane_lsb(l, DATA_W) +: DATA_W];
`else
    assign din = bus.ifm_input[lane_lsb(l, DATA_W) +: DATA_W];
`endif

    ifm_lane_shift #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (bus.flush),
      .en_i   (shift),
      .din_i  (din),
      .taps_o (taps)
    );

    assign bus.ifm_win[tap_lsb(l, 0, DEPTH, DATA_W) +: DEPTH*DATA_W] = taps;
  end

  always_comb begin
    fill_d  = fill_q;
    scnt_d  = scnt_q;
    valid_d = valid_q;
    if (bus.flush) begin
      fill_d  = '0;
      scnt_d  = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = 1'b0;
      if (bus.ifm_read) begin
        if (fill_q == FILL_LAST) begin
          // Completing shift: first window, stride phase restarts here.
          fill_d  = FILL_FULL;
          scnt_d  = '0;
          valid_d = 1'b1;
        end else if (fill_q == FILL_FULL) begin
          valid_d = (scnt_q == SC_LAST);
          scnt_d  = (scnt_q == SC_LAST) ? '0 : scnt_q + 1'b1;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q  <= '0;
      scnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      scnt_q  <= scnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.fill_cnt  = fill_q;
  assign bus.win_valid = valid_q;

endmodule

// File: tb/tb_ifm_win_buf.sv
// Scoreboard bench: two buffers (STRIDE=1 and STRIDE=2, DEPTH=4, LANES=2) share stimulus
// and are checked against a sample-history model.
module tb_ifm_win_buf;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int LN = 2;
`ifdef IFM_WIN_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef struct {
    logic [LN*DP*DW-1:0] win;
    logic                va;
    logic                vb;
    logic [2:0]          fill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifm_win_buf_if #(.DATA_W(DW), .DEPTH(DP), .LANES(LN)) bus_a ();
  ifm_win_buf_if #(.DATA_W(DW), .DEPTH(DP), .LANES(LN)) bus_b ();

  ifm_win_buf #(.DATA_W(DW), .DEPTH(DP), .LANES(LN), .STRIDE(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a.slave));
  ifm_win_buf #(.DATA_W(DW), .DEPTH(DP), .LANES(LN), .STRIDE(2)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b.slave));

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  // Reference state: samples shifted since the last clear (newest at back) and total count.
  logic [LN*DW-1:0] hist[$];
  int               n_shift = 0;
  logic             m_va = 1'b0, m_vb = 1'b0;

  function automatic bit win_hit(input int n, input int s);
    return (n >= DP) && (((n - DP) % s) == 0);
  endfunction

  function automatic logic [LN*DP*DW-1:0] model_win();
    logic [LN*DP*DW-1:0] w;
    logic [LN*DW-1:0]    smp;
    w = '0;
    for (int k = 0; k < DP; k++) begin
      if (k < hist.size()) begin
        smp = hist[hist.size() - 1 - k];
        for (int l = 0; l < LN; l++) w[(l*DP + k)*DW +: DW] = smp[l*DW +: DW];
      end
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic st, input logic rd, input logic fl,
                       input logic pd, input logic [LN*DW-1:0] din);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    bus_a.stall = st; bus_a.ifm_read = rd; bus_a.flush = fl; bus_a.ifm_input = din;
    bus_b.stall = st; bus_b.ifm_read = rd; bus_b.flush = fl; bus_b.ifm_input = din;
`ifdef IFM_WIN_PAD_EN
    bus_a.pad = pd; bus_b.pad = pd;
`endif
    if (!rn || fl) begin
      hist.delete();
      n_shift = 0;
      m_va = 1'b0; m_vb = 1'b0;
    end else if (!st) begin
      if (rd) begin
        hist.push_back((PAD_EN && pd) ? '0 : din);
        if (hist.size() > DP) void'(hist.pop_front());
        n_shift++;
        m_va = win_hit(n_shift, 1);
        m_vb = win_hit(n_shift, 2);
      end else begin
        m_va = 1'b0; m_vb = 1'b0;
      end
    end
    e.win  = model_win();
    e.va   = m_va;
    e.vb   = m_vb;
    e.fill = 3'((n_shift > DP) ? DP : n_shift);
    sb_q.push_back(e);
  endtask

  task automatic shift_in(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {l1, l0});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("win_a",   64'(bus_a.ifm_win),   64'(e.win));
        chk("win_b",   64'(bus_b.ifm_win),   64'(e.win));
        chk("valid_a", 64'(bus_a.win_valid), 64'(e.va));
        chk("valid_b", 64'(bus_b.win_valid), 64'(e.vb));
        chk("fill_a",  64'(bus_a.fill_cnt),  64'(e.fill));
        chk("fill_b",  64'(bus_b.fill_cnt),  64'(e.fill));
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    bus_a.stall = 1'b0; bus_a.ifm_read = 1'b0; bus_a.flush = 1'b0; bus_a.ifm_input = '0;
    bus_b.stall = 1'b0; bus_b.ifm_read = 1'b0; bus_b.flush = 1'b0; bus_b.ifm_input = '0;
`ifdef IFM_WIN_PAD_EN
    bus_a.pad = 1'b0; bus_b.pad = 1'b0;
`endif
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Fill 10..40, then 50 (window slides); lane 1 carries distinct data.
    shift_in(8'd10, 8'd1);
    shift_in(8'd20, 8'd2);
    shift_in(8'd30, 8'd3);
    shift_in(8'd40, 8'd4);
    shift_in(8'd50, 8'd5);
    // Stall with read while valid is high, then resume.
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5A5);
    shift_in(8'd60, 8'd6);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    // Flush beats stall and a concurrent read of -128.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8080);
    // Six continuous shifts 1..6 exercise both stride settings.
    for (int i = 1; i <= 6; i++) shift_in(8'(i), 8'(i + 100));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    // Signed extremes on independent lanes.
    shift_in(8'h80, 8'h7F);
    shift_in(8'h7F, 8'h80);
    // Reset mid-stream with nonzero taps, then refill.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    for (int i = 0; i < 5; i++) shift_in(8'(8'h11 * i), 8'(8'hF0 - i));
    // Pad shift (zero insertion) when the feature is built in.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5A5A);
    shift_in(8'h33, 8'h44);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 7) == 0),
            16'($urandom));
    end

    repeat (4) @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifm_win_buf.md
Name: ifm_win_buf

Overview:
Parametrised multi-lane IFM shift-window buffer. Next generation of the 4-tap, 8-bit single-lane IFM shift buffer. Each lane holds a DEPTH-tap window of signed activations that feeds the PE array. Adds fill tracking, strided window-valid generation, and a synchronous flush, so the PE controller no longer counts taps itself.

Parameters:
DATA_W, 8, signed activation width per tap
DEPTH, 4, taps per lane (>=2)
LANES, 1, parallel independent lanes sharing control
STRIDE, 1, shifts between successive window-valid pulses once full (>=1, <=DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall  in  1  freeze all state when high (flush excepted)
ifm_read  in  1  shift in one new sample per lane this cycle
flush  in  1  synchronous clear of window and counters
ifm_input  in  LANES*DATA_W  new samples; lane l at [l*DATA_W +: DATA_W]
ifm_win  out  LANES*DEPTH*DATA_W  tap k of lane l at [(l*DEPTH+k)*DATA_W +: DATA_W]; tap 0 is newest
win_valid  out  1  window complete and on stride boundary
fill_cnt  out  $clog2(DEPTH+1)  valid taps held, saturates at DEPTH

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low on rst_n. All state updates on posedge clk only.
- Reset (rst_n=0 at posedge): all taps 0; fill_cnt 0; stride counter 0; win_valid 0.
- Priority each cycle: reset > flush > stall > shift > hold.
- flush=1: same clear as reset. Ignores stall. A simultaneous ifm_read sample is dropped.
- shift = ifm_read & ~stall & ~flush. On shift, per lane: tap[k] <= tap[k-1] for k=DEPTH-1..1, and tap[0] <= lane input. The oldest tap is discarded.
- stall=1 without flush: taps, fill_cnt, stride counter and win_valid all hold, including a high win_valid.
- fill_cnt: +1 per shift until it reaches DEPTH, then stays at DEPTH.
- Stride counter scnt, range 0..STRIDE-1:
  - Cleared on the shift that makes fill_cnt reach DEPTH.
  - On later shifts: scnt <= (scnt==STRIDE-1) ? 0 : scnt+1.
- win_valid is registered, so it is aligned with the updated ifm_win. On a non-stalled cycle it is 1 iff that cycle's shift either (a) made fill_cnt reach DEPTH, or (b) occurred with fill_cnt==DEPTH and scnt==STRIDE-1.
- Non-stalled cycle with no shift: win_valid <= 0. win_valid is therefore a one-cycle pulse per qualifying shift, stretched only by stall.
- Latency: sample to tap 0 is one cycle. It reaches tap DEPTH-1 after DEPTH shifts.
- Arithmetic: data moves unchanged (no sign extension, no arithmetic). Lanes are independent data paths with shared control.
- Reset or flush mid-window: partial window discarded; the next win_valid needs DEPTH fresh shifts.

Optional Feature:
Macro IFM_WIN_PAD_EN.
- Defined: adds input port pad (1 bit). A shift with pad=1 inserts 0 into tap 0 of every lane, ignoring ifm_input. It counts toward fill_cnt and stride like a normal shift. Used for convolution border zero-padding.
- Undefined: no pad port; tap 0 always loads ifm_input.

Decomposition:
- Shared package ifm_pkg: DATA_W default, the fill-count width function ($clog2(DEPTH+1)), and a tap-slice index helper.
- One natural sub-module: ifm_lane_shift (DEPTH-tap shift register for a single lane, enable plus clear), instantiated LANES times by generate.
- Counters and win_valid live in the top level.

Test Plan:
- Reset: drive rst_n=0 mid-stream with taps nonzero -> next cycle all ifm_win=0, fill_cnt=0, win_valid=0.
- Fill, DEPTH=4, STRIDE=1: shift 10,20,30,40 -> win_valid first high after 40, taps {40,30,20,10}. Shifting 50 -> win_valid=1 again, taps {50,40,30,20}.
- Stride, STRIDE=2: 6 continuous shifts of 1..6 -> win_valid high after samples 4 and 6 only; fill_cnt stays 4.
- Stall: stall=1 with ifm_read=1 for 3 cycles while win_valid=1 -> taps, fill_cnt and win_valid unchanged; resumes correctly on release.
- Flush vs. read: flush=1 and ifm_read=1 with input -128, stall=1 -> all taps 0, fill_cnt 0; -128 not captured.
- LANES=2, signed edge: lane0 inputs -128,127 and lane1 inputs 127,-128 -> each lane holds its own values bit-exact. With IFM_WIN_PAD_EN: a pad=1 shift puts 0 in tap 0 of both lanes and increments fill_cnt.
